// File: rtl/hazard_ctrl_param_pkg.sv
// Shared types for the ID-stage hazard controller: FSM state encoding and next-PC select codes.
package hazard_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    BR_EVAL  = 3'd2,
    BR_TAKEN = 3'd3,
    JUMP     = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_PC4    = 2'b00;
  localparam logic [1:0] ADDR_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_BRANCH = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_param_if.sv
// ID-stage hazard bus: decode/EX observations in, pipeline write enables and PC select out.
interface hazard_ctrl_param_if #(
  parameter int REG_AW = 5
);
  logic              Jump;
  logic              Branch;
  logic              ALUZero;
  logic              memReadEX;
  logic              UseShamt;
  logic              UseImmed;
  logic [REG_AW-1:0] currRs;
  logic [REG_AW-1:0] currRt;
  logic [REG_AW-1:0] prevRt;
  logic              Flush;
  logic              IFwrite;
  logic              PC_write;
  logic              bubble;
  logic [1:0]        addrSel;
  logic              busy;

  modport master (
    output Jump, Branch, ALUZero, memReadEX, UseShamt, UseImmed,
    output currRs, currRt, prevRt, Flush,
    input  IFwrite, PC_write, bubble, addrSel, busy
  );

  modport slave (
    input  Jump, Branch, ALUZero, memReadEX, UseShamt, UseImmed,
    input  currRs, currRt, prevRt, Flush,
    output IFwrite, PC_write, bubble, addrSel, busy
  );
endinterface

// File: rtl/hazard_ctrl_param_penalty_cnt.sv
// Loadable down-counter that times stall/penalty windows; load wins over decrement, holds at zero.
module hazard_penalty_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl_param.sv
// Load-use / jump / branch hazard sequencer beside ID; Moore outputs decoded from state + penalty count.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt / flush_cnt performance counters.
module hazard_ctrl_param
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL     = 1,
  parameter int BRANCH_PENALTY = 2,
  parameter int JUMP_PENALTY   = 1,
  parameter int CNT_W          = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  hazard_ctrl_param_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MAX_PEN = max3(LOAD_STALL, BRANCH_PENALTY, JUMP_PENALTY);
  localparam int CW      = $clog2(MAX_PEN) + 1;

  if (LOAD_STALL < 1 || LOAD_STALL > 8) begin : g_bad_load
    $error("LOAD_STALL must be in 1..8");
  end
  if (BRANCH_PENALTY < 1 || BRANCH_PENALTY > 8) begin : g_bad_branch
    $error("BRANCH_PENALTY must be in 1..8");
  end
  if (JUMP_PENALTY < 1 || JUMP_PENALTY > 8) begin : g_bad_jump
    $error("JUMP_PENALTY must be in 1..8");
  end
  if (REG_AW < 1 || CNT_W < 1) begin : g_bad_width
    $error("REG_AW and CNT_W must be positive");
  end

  state_t          r_state;
  state_t          w_next;
  logic            w_ld_haz;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic [CW-1:0]   w_cnt_val;
  logic [CW-1:0]   w_cnt;
  logic            w_cnt_zero;
  logic            w_ifwrite;
  logic            w_pc_write;
  logic            w_bubble;
  logic [1:0]      w_addr_sel;
  logic            w_busy;

  // Rt only counts as a source when the instruction uses neither immediate nor shamt.
  assign w_ld_haz = bus.memReadEX && (bus.prevRt != '0) &&
                    ((bus.currRs == bus.prevRt) ||
                     (!bus.UseImmed && !bus.UseShamt && (bus.currRt == bus.prevRt)));

  hazard_penalty_cnt #(.W(CW)) u_cnt (
    .clk     (Clk),
    .rst_n   (Rst),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_val),
    .i_dec   (w_cnt_dec),
    .o_value (w_cnt),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    w_ifwrite  = 1'b1;
    w_pc_write = 1'b1;
    w_bubble   = 1'b0;
    w_addr_sel = ADDR_PC4;
    w_busy     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_ld_haz) begin
          w_next     = LOAD;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(LOAD_STALL - 1);
        end else if (bus.Jump) begin
          w_next     = JUMP;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(JUMP_PENALTY - 1);
        end else if (bus.Branch) begin
          w_next     = BR_EVAL;
        end
      end
      LOAD: begin
        w_ifwrite  = 1'b0;
        w_pc_write = 1'b0;
        w_bubble   = 1'b1;
        w_busy     = 1'b1;
        if (w_cnt_zero) w_next = IDLE;
        else            w_cnt_dec = 1'b1;
      end
      BR_EVAL: begin
        w_ifwrite  = 1'b0;
        w_pc_write = 1'b0;
        w_bubble   = 1'b1;
        w_busy     = 1'b1;
        if (bus.ALUZero) begin
          w_next     = BR_TAKEN;
          w_cnt_load = 1'b1;
          w_cnt_val  = CW'(BRANCH_PENALTY - 1);
        end else begin
          w_next     = IDLE;
        end
      end
      BR_TAKEN: begin
        w_ifwrite = 1'b0;
        w_bubble  = 1'b1;
        w_busy    = 1'b1;
        // The branch target is committed to the PC only in the final penalty cycle.
        if (w_cnt_zero) begin
          w_pc_write = 1'b1;
          w_addr_sel = ADDR_BRANCH;
          w_next     = IDLE;
        end else begin
          w_pc_write = 1'b0;
          w_cnt_dec  = 1'b1;
        end
      end
      JUMP: begin
        w_ifwrite = 1'b0;
        w_bubble  = 1'b1;
        w_busy    = 1'b1;
        // Entry cycle is recognised by the counter still holding its load value.
        if (w_cnt == CW'(JUMP_PENALTY - 1)) begin
          w_pc_write = 1'b1;
          w_addr_sel = ADDR_JUMP;
        end else begin
          w_pc_write = 1'b0;
        end
        if (w_cnt_zero) w_next = IDLE;
        else            w_cnt_dec = 1'b1;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_load = 1'b1;
        w_cnt_val  = '0;
      end
    endcase

    if (bus.Flush) begin
      w_next     = IDLE;
      w_cnt_load = 1'b1;
      w_cnt_val  = '0;
      w_cnt_dec  = 1'b0;
    end
  end

  assign bus.IFwrite  = w_ifwrite;
  assign bus.PC_write = w_pc_write;
  assign bus.bubble   = w_bubble;
  assign bus.addrSel  = w_addr_sel;
  assign bus.busy     = w_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == LOAD) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (((r_state == BR_EVAL) || (r_state == BR_TAKEN) || (r_state == JUMP)) &&
          (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
